expr_stim_driver: RTL and testbench

//  Other end of the packed expression-block interface. Drives the twelve operand buses
//  a0..a5/b0..b5 into an expression DUT from a seeded 64-bit LFSR and captures the packed
//  90-bit y result. Each captured y goes out on a valid/ready result stream and is folded

---
 rtl/expr_pkg.sv | 70 +++++++
 rtl/expr_stim_driver_if.sv | 29 ++
 rtl/expr_lfsr64.sv | 27 ++
 rtl/expr_stim_driver.sv | 145 ++++++++++++++
 tb/tb_expr_stim_driver.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/expr_pkg.sv
// Shared types, widths and helper functions for the expression stimulus driver.
// Operand and result layouts are packed structs, so field offsets follow from declaration order.
package expr_pkg;

    localparam int unsigned A0_W      = 4;
    localparam int unsigned A1_W      = 5;
    localparam int unsigned A2_W      = 6;
    localparam int unsigned A3_W      = 4;
    localparam int unsigned A4_W      = 5;
    localparam int unsigned A5_W      = 6;
    localparam int unsigned Y_FIELD_W = 5;
    localparam int unsigned LFSR_W    = 64;
    localparam int unsigned SIG_W     = 32;
    localparam int unsigned IDX_W     = 16;
    localparam int unsigned WAIT_W    = 3;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [SIG_W-1:0]  MISR_POLY = 32'h04C1_1DB7;

    // MSB-first operand layout: a0 occupies the top bits of the 60-bit image
    typedef struct packed {
        logic        [A0_W-1:0] a0;
        logic        [A1_W-1:0] a1;
        logic        [A2_W-1:0] a2;
        logic signed [A3_W-1:0] a3;
        logic signed [A4_W-1:0] a4;
        logic signed [A5_W-1:0] a5;
        logic        [A0_W-1:0] b0;
        logic        [A1_W-1:0] b1;
        logic        [A2_W-1:0] b2;
        logic signed [A3_W-1:0] b3;
        logic signed [A4_W-1:0] b4;
        logic signed [A5_W-1:0] b5;
    } ops_t;

    // Packed DUT result, y0 at the MSBs
    typedef struct packed {
        logic [Y_FIELD_W-1:0] y0, y1, y2, y3, y4, y5, y6, y7, y8;
        logic [Y_FIELD_W-1:0] y9, y10, y11, y12, y13, y14, y15, y16, y17;
    } y_t;

    localparam int unsigned OPS_W = $bits(ops_t);
    localparam int unsigned Y_W   = $bits(y_t);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    // An all-zero LFSR would lock up, so zero maps to 1
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic [Y_W-1:0]   y);
        logic [SIG_W-1:0] fold;
        fold = SIG_W'(y[Y_W-1:2*SIG_W]) ^ y[2*SIG_W-1:SIG_W] ^ y[SIG_W-1:0];
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0) ^ fold;
    endfunction

endpackage

// File: rtl/expr_stim_driver_if.sv
// Operand, result-capture and result-stream bundle between the stimulus driver and its neighbours.
interface expr_stim_driver_if;
    import expr_pkg::*;

    logic        [A0_W-1:0] a0, b0;
    logic        [A1_W-1:0] a1, b1;
    logic        [A2_W-1:0] a2, b2;
    logic signed [A3_W-1:0] a3, b3;
    logic signed [A4_W-1:0] a4, b4;
    logic signed [A5_W-1:0] a5, b5;
    logic [Y_W-1:0]         y_in;
    logic                   res_valid;
    logic                   res_ready;
    logic [Y_W-1:0]         res_data;
    logic [IDX_W-1:0]       res_idx;

    modport master (
        output a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5,
        output res_valid, res_data, res_idx,
        input  y_in, res_ready
    );

    modport slave (
        input  a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5,
        input  res_valid, res_data, res_idx,
        output y_in, res_ready
    );

endinterface

// File: rtl/expr_lfsr64.sv
// 64-bit Galois LFSR (right shift) with synchronous reload of the fixed seed.
module expr_lfsr64
    import expr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 64'h1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_FIX = seed_fix(SEED);

    // load has priority so a new run always starts from the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_FIX;
        end else if (load) begin
            state <= SEED_FIX;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/expr_stim_driver.sv
// Drives LFSR operands into an expression block, captures its packed result,
// streams each result out on valid/ready and folds it into a MISR signature.
module expr_stim_driver
    import expr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED        = 64'h1,
    parameter int unsigned       NUM_VECTORS = 256,
    parameter int unsigned       CAP_LAT     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [SIG_W-1:0]   sig,
    expr_stim_driver_if.master bus
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((CAP_LAT == 0) ? 0 : CAP_LAT - 1);

    state_t             state_q, state_d;
    ops_t               ops_q, ops_d;
    logic [Y_W-1:0]     res_data_q, res_data_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic               res_valid_q, res_valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               busy_d, done_d;
    logic [SIG_W-1:0]   sig_d;
    logic               lfsr_load, lfsr_step;
    logic [LFSR_W-1:0]  lfsr_state;

    expr_lfsr64 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ops_q       <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            idx_q       <= '0;
            wait_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sig         <= '0;
        end else begin
            state_q     <= state_d;
            ops_q       <= ops_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= res_valid_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            busy        <= busy_d;
            done        <= done_d;
            sig         <= sig_d;
        end
    end

    // Next state and next register values; done is a single-cycle pulse by default
    always_comb begin
        state_d     = state_q;
        ops_d       = ops_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_valid_d = res_valid_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        busy_d      = busy;
        done_d      = 1'b0;
        sig_d       = sig;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    idx_d     = '0;
                    sig_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                ops_d   = ops_t'(OPS_W'(lfsr_state));
                wait_d  = '0;
                state_d = (CAP_LAT == 0) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            CAPTURE: begin
                res_data_d  = bus.y_in;
                res_idx_d   = idx_q;
                sig_d       = misr_next(sig, bus.y_in);
                res_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                // Record and operands hold until the consumer takes it
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    lfsr_step   = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = DRIVE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {bus.a0, bus.a1, bus.a2, bus.a3, bus.a4, bus.a5,
            bus.b0, bus.b1, bus.b2, bus.b3, bus.b4, bus.b5} = ops_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

endmodule

// File: tb/tb_expr_stim_driver.sv
// Directed bench for expr_stim_driver: several parameterisations share one clock and reset.
module tb_expr_stim_driver;
    import expr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // s1: seed 1, one vector, CAP_LAT 0; s0: seed 0; two: two vectors; four/eight: CAP_LAT 3
    logic start_s1, start_s0, start_two, start_four, start_eight;
    logic busy_s1, busy_s0, busy_two, busy_four, busy_eight;
    logic done_s1, done_s0, done_two, done_four, done_eight;
    logic [31:0] sig_s1, sig_s0, sig_two, sig_four, sig_eight;

    expr_stim_driver_if bus_s1();
    expr_stim_driver_if bus_s0();
    expr_stim_driver_if bus_two();
    expr_stim_driver_if bus_four();
    expr_stim_driver_if bus_eight();

    expr_stim_driver #(.SEED(64'h1), .NUM_VECTORS(1), .CAP_LAT(0)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_s1), .busy(busy_s1), .done(done_s1),
        .sig(sig_s1), .bus(bus_s1));
    expr_stim_driver #(.SEED(64'h0), .NUM_VECTORS(1), .CAP_LAT(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_s0), .busy(busy_s0), .done(done_s0),
        .sig(sig_s0), .bus(bus_s0));
    expr_stim_driver #(.SEED(64'h1), .NUM_VECTORS(2), .CAP_LAT(0)) u_two (
        .clk(clk), .rst_n(rst_n), .start(start_two), .busy(busy_two), .done(done_two),
        .sig(sig_two), .bus(bus_two));
    expr_stim_driver #(.SEED(64'h1), .NUM_VECTORS(4), .CAP_LAT(3)) u_four (
        .clk(clk), .rst_n(rst_n), .start(start_four), .busy(busy_four), .done(done_four),
        .sig(sig_four), .bus(bus_four));
    expr_stim_driver #(.SEED(64'h1), .NUM_VECTORS(8), .CAP_LAT(3)) u_eight (
        .clk(clk), .rst_n(rst_n), .start(start_eight), .busy(busy_eight), .done(done_eight),
        .sig(sig_eight), .bus(bus_eight));

    logic [59:0] ops_s1, ops_s0, ops_four, ops_eight;
    assign ops_s1    = {bus_s1.a0, bus_s1.a1, bus_s1.a2, bus_s1.a3, bus_s1.a4, bus_s1.a5,
                        bus_s1.b0, bus_s1.b1, bus_s1.b2, bus_s1.b3, bus_s1.b4, bus_s1.b5};
    assign ops_s0    = {bus_s0.a0, bus_s0.a1, bus_s0.a2, bus_s0.a3, bus_s0.a4, bus_s0.a5,
                        bus_s0.b0, bus_s0.b1, bus_s0.b2, bus_s0.b3, bus_s0.b4, bus_s0.b5};
    assign ops_four  = {bus_four.a0, bus_four.a1, bus_four.a2, bus_four.a3, bus_four.a4,
                        bus_four.a5, bus_four.b0, bus_four.b1, bus_four.b2, bus_four.b3,
                        bus_four.b4, bus_four.b5};
    assign ops_eight = {bus_eight.a0, bus_eight.a1, bus_eight.a2, bus_eight.a3, bus_eight.a4,
                        bus_eight.a5, bus_eight.b0, bus_eight.b1, bus_eight.b2, bus_eight.b3,
                        bus_eight.b4, bus_eight.b5};

    // The four-vector instance sees a result equal to its operand image
    assign bus_four.y_in = 90'(ops_four);

    int done_cnt_four  = 0;
    int done_cnt_eight = 0;
    always @(negedge clk) begin
        if (done_four)  done_cnt_four++;
        if (done_eight) done_cnt_eight++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [89:0] exp_rd [0:3];
    int          n;
    logic        ok;

    initial begin
        exp_rd[0] = 90'h1;
        exp_rd[1] = 90'h800000000000000;
        exp_rd[2] = 90'hC00000000000000;
        exp_rd[3] = 90'h600000000000000;

        rst_n = 1'b0;
        start_s1 = 1'b0; start_s0 = 1'b0; start_two = 1'b0; start_four = 1'b0; start_eight = 1'b0;
        bus_s1.y_in = '0;       bus_s1.res_ready = 1'b1;
        bus_s0.y_in = '0;       bus_s0.res_ready = 1'b1;
        bus_two.y_in = 90'h1;   bus_two.res_ready = 1'b1;
        bus_four.res_ready = 1'b0;
        bus_eight.y_in = 90'h5; bus_eight.res_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_outs", 128'({busy_s1, done_s1, bus_s1.res_valid, sig_s1, bus_s1.res_idx, ops_s1}), '0);
        chk("rst_data", 128'(bus_s1.res_data), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector from seed 1, result sampled one cycle after DRIVE
        start_s1 = 1'b1; bus_s1.y_in = 90'h111;
        @(negedge clk);
        start_s1 = 1'b0; bus_s1.y_in = 90'h222;
        chk("t1_busy", 128'(busy_s1), 128'd1);
        @(negedge clk);
        bus_s1.y_in = 90'h3A55A5A;
        chk("t1_ops", 128'(ops_s1), 128'h1);
        chk("t1_valid_early", 128'(bus_s1.res_valid), '0);
        @(negedge clk);
        bus_s1.y_in = 90'h444;
        chk("t1_valid", 128'(bus_s1.res_valid), 128'd1);
        chk("t1_data", 128'(bus_s1.res_data), 128'h3A55A5A);
        chk("t1_idx", 128'(bus_s1.res_idx), '0);
        @(negedge clk);
        chk("t1_done_pulse", 128'({done_s1, busy_s1, bus_s1.res_valid}), 128'b100);
        @(negedge clk);
        chk("t1_done_clear", 128'(done_s1), '0);
        chk("t1_sig", 128'(sig_s1), 128'h03A55A5A);

        // Constant zero result gives a zero signature, cleared at start
        bus_s1.y_in = '0;
        start_s1 = 1'b1;
        @(negedge clk);
        start_s1 = 1'b0;
        n = 0;
        while (!done_s1 && n < 20) begin @(negedge clk); n++; end
        chk("t4a_done_seen", 128'(done_s1), 128'd1);
        chk("t4a_sig_zero", 128'(sig_s1), '0);

        // Seed 0 behaves like seed 1
        start_s0 = 1'b1;
        @(negedge clk);
        start_s0 = 1'b0;
        @(negedge clk);
        chk("t2_seed0_ops", 128'(ops_s0), 128'h1);
        n = 0;
        while (!done_s0 && n < 20) begin @(negedge clk); n++; end
        chk("t2_done_seen", 128'(done_s0), 128'd1);

        // Two vectors of y=1 fold to signature 3
        start_two = 1'b1;
        @(negedge clk);
        start_two = 1'b0;
        n = 0;
        while (!done_two && n < 30) begin @(negedge clk); n++; end
        chk("t4b_done_seen", 128'(done_two), 128'd1);
        chk("t4b_sig", 128'(sig_two), 128'h3);
        repeat (3) @(negedge clk);
        chk("t4b_sig_hold", 128'(sig_two), 128'h3);

        // Four vectors with a ten-cycle stall on vector 2 and a start while busy
        start_four = 1'b1;
        @(negedge clk);
        start_four = 1'b0;
        for (int v = 0; v < 4; v++) begin
            n = 0;
            while (!bus_four.res_valid && n < 40) begin @(negedge clk); n++; end
            chk("t3_valid_seen", 128'(bus_four.res_valid), 128'd1);
            chk("t3_idx", 128'(bus_four.res_idx), 128'(v));
            chk("t3_data", 128'(bus_four.res_data), 128'(exp_rd[v]));
            if (v == 2) begin
                ok = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (bus_four.res_valid !== 1'b1 || bus_four.res_data !== exp_rd[2] ||
                        ops_four !== 60'hC00000000000000) ok = 1'b0;
                end
                chk("t3_stall_stable", 128'(ok), 128'd1);
            end
            if (v == 1) start_four = 1'b1;
            bus_four.res_ready = 1'b1;
            @(negedge clk);
            bus_four.res_ready = 1'b0;
            start_four = 1'b0;
        end
        chk("t6_done", 128'({done_four, busy_four}), 128'b10);
        start_four = 1'b1;
        @(negedge clk);
        start_four = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            if (busy_four !== 1'b0 || bus_four.res_valid !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("t6_no_restart", 128'(ok), 128'd1);
        chk("t6_done_count", 128'(done_cnt_four), 128'd1);

        // Reset during the WAIT of vector 5 aborts the run
        start_eight = 1'b1;
        @(negedge clk);
        start_eight = 1'b0;
        n = 0;
        while (!(bus_eight.res_valid && bus_eight.res_idx == 16'd4) && n < 60) begin
            @(negedge clk); n++;
        end
        chk("t5_reach_v4", 128'(bus_eight.res_valid && bus_eight.res_idx == 16'd4), 128'd1);
        chk("t5_v4_ops", 128'(ops_eight), 128'hB00000000000000);
        @(negedge clk);
        @(negedge clk);
        chk("t5_v5_ops", 128'(ops_eight), 128'hD80000000000000);
        chk("t5_busy_pre", 128'(busy_eight), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", 128'({busy_eight, done_eight, bus_eight.res_valid, sig_eight,
                                 bus_eight.res_idx, ops_eight}), '0);
        chk("t5_rst_data", 128'(bus_eight.res_data), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done", 128'(done_cnt_eight), '0);
        chk("t5_idle_busy", 128'(busy_eight), '0);
        start_eight = 1'b1;
        @(negedge clk);
        start_eight = 1'b0;
        @(negedge clk);
        chk("t5_replay_ops", 128'(ops_eight), 128'h1);
        n = 0;
        while (!bus_eight.res_valid && n < 20) begin @(negedge clk); n++; end
        chk("t5_replay_idx", 128'({bus_eight.res_valid, bus_eight.res_idx}), 128'h10000);
        n = 0;
        while (!done_eight && n < 80) begin @(negedge clk); n++; end
        chk("t5_full_done", 128'(done_eight), 128'd1);
        @(negedge clk);
        chk("t5_done_count", 128'(done_cnt_eight), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
